// File: rtl/interrupt_pkg.sv
// interrupt_pkg: shared types and constants for interrupt_controller.
//   int_state_t          - controller FSM state (IDLE, ASSERT, SERVICE)
//   NUM_SRC_DEFAULT      - default number of request lines
//   PULSE_CYCLES_DEFAULT - default interrupt_signal pulse length in cycles
//   CNT_W                - width of the pulse counter (covers PULSE_CYCLES up to 15)
//   vec_width()          - width of a source index, never less than 1
package interrupt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } int_state_t;

    localparam int unsigned NUM_SRC_DEFAULT      = 4;
    localparam int unsigned PULSE_CYCLES_DEFAULT = 1;
    localparam int unsigned CNT_W                = 4;

    function automatic int unsigned vec_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: combinational lowest-index-wins selector.
//   req   in  NUM_SRC - candidate vector (pending & ~mask)
//   valid out 1       - any candidate present
//   idx   out VEC_W   - lowest set index (0 when none)
module irq_priority_encoder #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned VEC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [VEC_W-1:0]   idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan from the top down so the lowest set bit is the last to write idx.
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (req[i-1]) begin
                idx = VEC_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches rising edges on irq lines as pending, masks
// them, and services the lowest-index unmasked source by pulsing
// interrupt_signal for PULSE_CYCLES cycles, then waits for int_done.
//   clk              in  1        - rising-edge clock
//   rst              in  1        - asynchronous active-high reset
//   irq              in  NUM_SRC  - request lines, rising edge raises a request
//   mask_we          in  1        - mask write strobe
//   mask_wdata       in  NUM_SRC  - new mask (1 = source disabled)
//   int_done         in  1        - handler-return pulse
//   interrupt_signal out 1        - interrupt pulse to the processor
//   int_vector       out VEC_W    - index of the source being serviced
//   busy             out 1        - high in ASSERT and SERVICE
//   pending          out NUM_SRC  - pending register
// Build option: define INTERRUPT_SYNC_EN to pass irq through a 2-flop
// synchronizer before edge detection (adds 2 cycles of latency).
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int unsigned NUM_SRC      = NUM_SRC_DEFAULT,
    parameter int unsigned PULSE_CYCLES = PULSE_CYCLES_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               irq,
    input  logic                             mask_we,
    input  logic [NUM_SRC-1:0]               mask_wdata,
    input  logic                             int_done,
    output logic                             interrupt_signal,
    output logic [vec_width(NUM_SRC)-1:0]    int_vector,
    output logic                             busy,
    output logic [NUM_SRC-1:0]               pending
);

    localparam int unsigned VEC_W = vec_width(NUM_SRC);

    int_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] irq_edge;
    logic [NUM_SRC-1:0] clr_vec;
    logic               sel_valid;
    logic [VEC_W-1:0]   sel_idx;

`ifdef INTERRUPT_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_s = sync_q2;
`else
    assign irq_s = irq;
`endif

    assign irq_edge = irq_s & ~irq_prev;

    irq_priority_encoder #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) u_prio (
        .req   (pending & ~mask),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    always_comb begin
        clr_vec = '0;
        if (state == IDLE && sel_valid) begin
            clr_vec = NUM_SRC'(1) << sel_idx;
        end
    end

    // Clear is applied before OR-ing in new edges, so a same-cycle edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
        end else begin
            irq_prev <= irq_s;
            pending  <= (pending & ~clr_vec) | irq_edge;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            int_vector       <= '0;
            interrupt_signal <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        int_vector       <= sel_idx;
                        cnt              <= CNT_W'(PULSE_CYCLES - 1);
                        state            <= ASSERT;
                        interrupt_signal <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (cnt == '0) begin
                        state            <= SERVICE;
                        interrupt_signal <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SERVICE: begin
                    if (int_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    interrupt_signal <= 1'b0;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: drives two controllers (PULSE_CYCLES 1 and 3) from
// the same inputs and compares both against a cycle-level reference model.
module tb_interrupt_controller;

`ifdef INTERRUPT_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] irq = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = '0;
    logic       int_done = 1'b0;

    logic       is0, busy0, is1, busy1;
    logic [1:0] vec0, vec1;
    logic [3:0] pend0, pend1;

    interrupt_controller #(.NUM_SRC(4), .PULSE_CYCLES(1)) u_dut_p1 (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .int_done(int_done), .interrupt_signal(is0), .int_vector(vec0), .busy(busy0),
        .pending(pend0)
    );

    interrupt_controller #(.NUM_SRC(4), .PULSE_CYCLES(3)) u_dut_p3 (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .int_done(int_done), .interrupt_signal(is1), .int_vector(vec1), .busy(busy1),
        .pending(pend1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_no  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = idle, 1 = pulsing, 2 = awaiting handler return.
    int         pulse_len [2] = '{1, 3};
    logic [3:0] m_pend [2];
    logic [3:0] m_mask [2];
    logic [3:0] m_prev [2];
    int         m_mode [2];
    int         m_left [2];
    int         m_vec  [2];
    logic [3:0] h0, h1;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0; m_mask[d] = '0; m_prev[d] = '0;
            m_mode[d] = 0;  m_left[d] = 0;  m_vec[d] = 0;
        end
        h0 = '0; h1 = '0;
    endtask

    task automatic model_edge();
        logic [3:0] sampled, rise, clr, cand;
        sampled = (S == 2) ? h1 : irq;
        h1 = h0;
        h0 = irq;
        for (int d = 0; d < 2; d++) begin
            rise = sampled & ~m_prev[d];
            m_prev[d] = sampled;
            clr = '0;
            if (m_mode[d] == 0) begin
                cand = m_pend[d] & ~m_mask[d];
                for (int i = 0; i < 4; i++) begin
                    if (cand[i] && clr == 4'b0) begin
                        clr[i] = 1'b1;
                        m_vec[d] = i;
                    end
                end
                if (clr != 4'b0) begin
                    m_mode[d] = 1;
                    m_left[d] = pulse_len[d];
                end
            end else if (m_mode[d] == 1) begin
                m_left[d] = m_left[d] - 1;
                if (m_left[d] == 0) m_mode[d] = 2;
            end else begin
                if (int_done) m_mode[d] = 0;
            end
            m_pend[d] = (m_pend[d] & ~clr) | rise;
            if (mask_we) m_mask[d] = mask_wdata;
        end
    endtask

    task automatic compare_all();
        check_val("p1_irq_sig", 32'(is0),   32'(m_mode[0] == 1));
        check_val("p1_busy",    32'(busy0), 32'(m_mode[0] != 0));
        check_val("p1_vector",  32'(vec0),  32'(m_vec[0]));
        check_val("p1_pending", 32'(pend0), 32'(m_pend[0]));
        check_val("p3_irq_sig", 32'(is1),   32'(m_mode[1] == 1));
        check_val("p3_busy",    32'(busy1), 32'(m_mode[1] != 0));
        check_val("p3_vector",  32'(vec1),  32'(m_vec[1]));
        check_val("p3_pending", 32'(pend1), 32'(m_pend[1]));
    endtask

    // Called at a falling edge: apply inputs, advance the model, sample at the next falling edge.
    task automatic step(input logic [3:0] irq_v, input logic we, input logic [3:0] wd, input logic done);
        irq        = irq_v;
        mask_we    = we;
        mask_wdata = wd;
        int_done   = done;
        model_edge();
        @(negedge clk);
        edge_no++;
        compare_all();
    endtask

    task automatic do_async_reset();
        mask_we  = 1'b0;
        int_done = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_val("rst_p1_irq_sig", 32'(is0),   0);
        check_val("rst_p1_busy",    32'(busy0), 0);
        check_val("rst_p1_vector",  32'(vec0),  0);
        check_val("rst_p1_pending", 32'(pend0), 0);
        check_val("rst_p3_irq_sig", 32'(is1),   0);
        check_val("rst_p3_busy",    32'(busy1), 0);
        check_val("rst_p3_pending", 32'(pend1), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        edge_no = 0;
        compare_all();
    endtask

    initial begin
        int first0;
        int hi1;
        logic [3:0] irq_r;

        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Single source 2, level held; int_done lands while the P=3 unit still pulses.
        first0 = -1;
        hi1    = 0;
        for (int e = 1; e <= 10 + S; e++) begin
            step((e >= 3) ? 4'b0100 : 4'b0000, 1'b0, 4'b0000, e == 6 + S);
            if (is0 && first0 < 0) first0 = edge_no;
            if (is1) hi1++;
            if (edge_no == 3 + S) check_val("t1_pending_after_edge", 32'(pend0), 32'h4);
        end
        check_val("t1_first_pulse_edge", 32'(first0), 32'(4 + S));
        check_val("t1_p3_pulse_len",     32'(hi1),    3);
        check_val("t1_p3_still_service", 32'(busy1),  1);
        check_val("t1_p1_level_once",    32'(busy0),  0);

        // Simultaneous edges on sources 1 and 3.
        step(4'b0000, 1'b0, 4'b0000, 1'b1);
        step(4'b1010, 1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 12 && !is0; k++) step(4'b1010, 1'b0, 4'b0000, 1'b0);
        check_val("t2_first_pulse", 32'(is0),  1);
        check_val("t2_first_vec",   32'(vec0), 1);
        step(4'b1010, 1'b0, 4'b0000, 1'b0);
        check_val("t2_in_service",  32'(busy0 & ~is0), 1);
        step(4'b1010, 1'b0, 4'b0000, 1'b1);
        check_val("t2_idle_after_done", 32'(busy0), 0);
        step(4'b1010, 1'b0, 4'b0000, 1'b0);
        check_val("t2_second_pulse", 32'(is0),  1);
        check_val("t2_second_vec",   32'(vec0), 3);

        // Masked source stays pending until unmasked.
        for (int k = 0; k < 14; k++) step(4'b0000, 1'b0, 4'b0000, 1'b1);
        step(4'b0000, 1'b1, 4'b0001, 1'b0);
        for (int k = 0; k < S + 3; k++) step(4'b0001, 1'b0, 4'b0000, 1'b0);
        check_val("t3_masked_no_pulse", 32'(is0),   0);
        check_val("t3_masked_pending",  32'(pend0), 32'h1);
        step(4'b0001, 1'b1, 4'b0000, 1'b0);
        check_val("t3_old_mask_used", 32'(is0), 0);
        step(4'b0001, 1'b0, 4'b0000, 1'b0);
        check_val("t3_unmask_pulse", 32'(is0),  1);
        check_val("t3_unmask_vec",   32'(vec0), 0);

        // Reset while servicing with sources 1 and 2 pending.
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b0, 4'b0000, 1'b1);
        step(4'b0001, 1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 10 && !(busy0 && !is0); k++) step(4'b0001, 1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < S + 1; k++) step(4'b0111, 1'b0, 4'b0000, 1'b0);
        check_val("t5_busy_before_rst",    32'(busy0), 1);
        check_val("t5_pending_before_rst", 32'(pend0), 32'h6);
        do_async_reset();

        // Randomized traffic with periodic mid-operation resets.
        irq_r = irq;
        for (int c = 0; c < 600; c++) begin
            irq_r = irq_r ^ 4'($urandom & $urandom & $urandom);
            step(irq_r, $urandom_range(0, 9) == 0, 4'($urandom & $urandom), $urandom_range(0, 2) == 0);
            if (c % 150 == 149) do_async_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt source side of the processor's `interrupt_signal` input. It collects up to `NUM_SRC` external request lines, latches rising edges as pending, applies a software-written mask, and selects the highest-priority unmasked source. It then drives `interrupt_signal` high for a fixed pulse, and holds off further interrupts until the processor reports the handler's return through `int_done`. It sits beside `processor` at the top level.

## Interface
Parameters:
- `NUM_SRC`, 4 — number of request lines, 1..16.
- `PULSE_CYCLES`, 1 — cycles `interrupt_signal` stays high per interrupt, 1..15.

Ports:
- `clk`  in  1 — single clock; every register uses the rising edge.
- `rst`  in  1 — asynchronous, active-high reset.
- `irq`  in  NUM_SRC — external request lines; a rising edge raises a request.
- `mask_we`  in  1 — mask write strobe.
- `mask_wdata`  in  NUM_SRC — new mask value; bit = 1 disables that source.
- `int_done`  in  1 — one-cycle pulse when the handler returns (RTI retires).
- `interrupt_signal`  out  1 — to `processor.interrupt_signal`.
- `int_vector`  out  $clog2(NUM_SRC) (min 1) — index of the source being serviced.
- `busy`  out  1 — high in ASSERT and SERVICE.
- `pending`  out  NUM_SRC — pending register, for debug and visibility.

## Operation
- Edge detect:
  - `irq_prev` register; `edge = irq & ~irq_prev`.
  - On each clock edge, `pending |= edge`.
- Mask:
  - `mask` register, written on `mask_we`.
  - Reset value is all zeros, so every source is enabled.
- Priority: the lowest index among `pending & ~mask` wins.
- FSM states are IDLE, ASSERT and SERVICE.
  - IDLE → ASSERT when any unmasked pending bit exists. On that edge:
    - latch the winner into `int_vector`;
    - clear its pending bit;
    - load `cnt = PULSE_CYCLES-1`.
  - ASSERT: `interrupt_signal` is 1 and `cnt` decrements. When `cnt == 0` → SERVICE.
  - SERVICE: wait for `int_done`, then → IDLE.
  - `int_done` in IDLE or ASSERT is ignored.
- Boundary rules:
  - A new edge on a source in the same cycle its bit is being cleared: set wins, and the bit stays pending.
  - Masked pending bits are retained; unmasking them later triggers service.
  - Edges arriving in ASSERT or SERVICE only accumulate in `pending`. No nesting.
  - `mask_we` in the cycle a selection happens: the selection uses the old mask.
  - A level held high produces exactly one request.
- Reset, asynchronous and including reset mid-operation:
  - state = IDLE;
  - `pending`, `mask`, `int_vector`, `cnt` = 0;
  - `irq_prev` = 0, so a line already high when reset releases is treated as an edge;
  - all outputs = 0.

## Timing
- `irq[i]` is sampled high at edge k with `irq_prev[i]` = 0.
  - `pending[i]` = 1 after edge k.
  - State = ASSERT after edge k+1.
  - `interrupt_signal` is high for cycles k+1 .. k+PULSE_CYCLES.
- Back-to-back interrupts: `int_done` at edge m puts the FSM in IDLE after edge m. The next interrupt can reach ASSERT after edge m+1.
- `interrupt_signal`, `busy` and `int_vector` are decoded from registers only, so they do not glitch.

## Configuration
- `INTERRUPT_SYNC_EN`
  - Defined: `irq` passes through a 2-flop synchronizer before edge detect, and all latencies grow by 2 cycles. Reset clears the synchronizer flops to 0.
  - Undefined: `irq` is treated as synchronous to `clk` and feeds edge detect directly.

## Structure
- `interrupt_pkg` holds:
  - the `int_state_t` enum (IDLE, ASSERT, SERVICE);
  - the `NUM_SRC_DEFAULT` and `PULSE_CYCLES_DEFAULT` constants.
- Sub-module `irq_priority_encoder` (combinational):
  - input: the `pending & ~mask` vector;
  - outputs: `valid` and the lowest set index.

## Test plan
- Reset, then `irq` = 4'b0100 from cycle 3 → `pending` = 0100 after edge 3, `interrupt_signal` high cycle 4 only, `int_vector` = 2, `busy` stays 1 until `int_done`.
- `irq` = 4'b1010 rising together → source 1 is serviced first. `int_done` is pulsed; source 3 is then serviced with `int_vector` = 3, two cycles after `int_done`.
- `mask` = 4'b0001, then `irq[0]` rises → no pulse and `pending[0]` = 1. Writing `mask` = 0 → pulse with `int_vector` = 0 after the following edge.
- `PULSE_CYCLES` = 3 → `interrupt_signal` high exactly 3 cycles. `int_done` pulsed during ASSERT is ignored; the FSM still waits in SERVICE.
- Assert `rst` during SERVICE with `pending` = 0110 → all outputs and `pending` go to 0 immediately, and the FSM is in IDLE.
- With `INTERRUPT_SYNC_EN` defined → the first interrupt pulse arrives exactly 2 cycles later than in the first test.
